calc_operand_entry: RTL and testbench
=====================================

# calc_operand_entry

Button-driven operand and operator entry sequencer sitting on the input side of the calculator display path. It synchronizes and debounces two raw push-buttons, then steps the user through entering A, OP and B from the slide switches. It presents stable, registered `A`, `B`, `OP` to the calculator/display datapath, plus a `valid` level and a one-cycle `new_result` strobe once a full expression is captured.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000. Consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz). Must be ≥ 1.

Ports:
- `clk`  input  1  System clock; all flops on the rising edge.
- `rst_n`  input  1  Reset, asynchronous, active-low.
- `sw`  input  4  Raw slide switches; value to capture.
- `btn_next`  input  1  Raw, asynchronous "enter/advance" push-button, active-high.
- `btn_clear`  input  1  Raw, asynchronous "clear" push-button, active-high.
- `A`  output  4  Captured operand A.
- `B`  output  4  Captured operand B.
- `OP`  output  2  Captured operator; same encoding the calculator consumes.
- `stage`  output  2  Current FSM state, for the entry-prompt display.
- `valid`  output  1  High while a complete A/OP/B set is held.
- `new_result`  output  1  One-cycle strobe on entry to S_DONE.

## Operation
- Each button passes through a 2-flop synchronizer, then the debouncer (see Configuration), then a registered rising-edge detector producing a 1-cycle pulse (`next_p`, `clear_p`). A release edge produces no pulse.
- Debouncer: a counter of width clog2(DEBOUNCE_CYCLES+1) resets whenever the synchronized level equals the debounced level. Otherwise it increments, and when it reaches DEBOUNCE_CYCLES the debounced level takes the synchronized value and the counter clears. Any glitch shorter than DEBOUNCE_CYCLES is discarded.
- FSM states (the `stage` encoding):
  - S_A=00: on `next_p`, A ← sw, go to S_OP.
  - S_OP=01: on `next_p`, OP ← sw[1:0], go to S_B.
  - S_B=10: on `next_p`, B ← sw, `valid` ← 1, `new_result` pulses, go to S_DONE.
  - S_DONE=11: on `next_p`, `valid` ← 0, go to S_A. A, B and OP hold their values until overwritten.
- `clear_p` in any state: A, B, OP ← 0, `valid` ← 0, go to S_A.
- `clear_p` and `next_p` in the same cycle: clear wins and `next_p` is dropped.
- `sw` is sampled only on the capture edge. Switch changes at other times have no effect.
- All outputs are registered. Reset values: A=0, B=0, OP=0, stage=00, `valid`=0, `new_result`=0. Synchronizers, debounced levels, counters and edge-detect flops all reset to 0.
- Asserting reset mid-entry aborts immediately to S_A with all outputs 0. A button held through reset release produces one pulse after debounce, because the debounced level was reset to 0.

## Timing
- Raw button rising at edge k, held stable: the pulse is high for exactly one cycle, after edge k+3+DEBOUNCE_CYCLES with the macro and after edge k+3 without it.
- The FSM and captured registers update on the edge following the pulse, so outputs change 1 cycle after the pulse.
- `new_result` is high for exactly the one cycle in which `stage` first reads 11.
- Minimum spacing between accepted presses: 2×DEBOUNCE_CYCLES + 2 cycles (press, then release).

## Configuration
- `CALC_ENTRY_DEBOUNCE_EN` defined: the debouncer described above is instantiated.
- Undefined: the debouncer is removed and the synchronized level feeds the edge detector directly. `DEBOUNCE_CYCLES` is ignored. This mode is used for fast simulation and for pre-debounced inputs.

## Test plan
- Reset asserted mid-S_B with A=5 captured → A=B=OP=0, stage=00, `valid`=0 asynchronously; after release, FSM idles in S_A.
- DEBOUNCE_CYCLES=4, macro on: sw=3, clean press of `btn_next` → `next_p` at edge k+7, A=3 and stage=01 at edge k+8. Then sw=2, press → OP=2. Then sw=9, press → B=9, `valid`=1, `new_result` high one cycle.
- DEBOUNCE_CYCLES=4, macro on: 3-cycle glitch on `btn_next`, then bounces of 1–3 cycles → no pulse and stage unchanged. A bounce followed by 6 stable cycles → exactly one pulse.
- In S_DONE with A=3, OP=2, B=9, press next → stage=00, `valid`=0, A/B/OP still 3/2/9. Then sw=7, press → A=7.
- Buttons pressed so `clear_p` and `next_p` coincide in S_OP → stage=00, all captured values 0, no OP capture.
- Macro off: press `btn_next` at edge k → pulse at edge k+3 and state change at k+4. Holding the button 100 cycles → a single advance.

Source files
------------

// File: rtl/calc_operand_entry.sv
// Operand/operator entry sequencer: sync + debounce two buttons, then step through A, OP, B capture.
// Latency: button edge to pulse 3 cycles (+DEBOUNCE_CYCLES with CALC_ENTRY_DEBOUNCE_EN), outputs 1 cycle later.
// Backpressure: none; presses are consumed as they arrive and all outputs are registered levels/strobes.
module calc_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [1:0] OP,
    output logic [1:0] stage,
    output logic       valid,
    output logic       new_result
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_OP   = 2'b01,
        S_B    = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // bit 0 = next, bit 1 = clear
    logic [1:0] btn_raw;
    logic [1:0] sync1, sync2;
    logic [1:0] lvl, lvl_q;
    logic [1:0] pulse;
    logic       next_p, clear_p;

    assign btn_raw = {btn_clear, btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef CALC_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          db;

        // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                db  <= 1'b0;
            end else if (sync2[i] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign lvl[i] = db;
    end
`else
    logic cfg_unused;
    assign cfg_unused = |DEBOUNCE_CYCLES;

    // Keeps the pulse timing identical in shape to the debounced build, minus the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= 2'b00;
        end else begin
            lvl <= sync2;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 2'b00;
            pulse <= 2'b00;
        end else begin
            lvl_q <= lvl;
            pulse <= lvl & ~lvl_q;
        end
    end

    assign next_p  = pulse[0];
    assign clear_p = pulse[1];

    state_t     state_q, state_d;
    logic [3:0] a_d, b_d;
    logic [1:0] op_d;
    logic       valid_d, new_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            A          <= 4'h0;
            B          <= 4'h0;
            OP         <= 2'b00;
            valid      <= 1'b0;
            new_result <= 1'b0;
        end else begin
            state_q    <= state_d;
            A          <= a_d;
            B          <= b_d;
            OP         <= op_d;
            valid      <= valid_d;
            new_result <= new_d;
        end
    end

    // Clear has priority; a coincident next press is dropped.
    always_comb begin
        state_d = state_q;
        a_d     = A;
        b_d     = B;
        op_d    = OP;
        valid_d = valid;
        new_d   = 1'b0;
        if (clear_p) begin
            state_d = S_A;
            a_d     = 4'h0;
            b_d     = 4'h0;
            op_d    = 2'b00;
            valid_d = 1'b0;
        end else if (next_p) begin
            case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = sw[1:0];
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    valid_d = 1'b1;
                    new_d   = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign stage = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry; works with or without CALC_ENTRY_DEBOUNCE_EN defined.
module tb_calc_operand_entry;

    localparam int DB = 4;
`ifdef CALC_ENTRY_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_next, btn_clear;
    logic [3:0] A, B;
    logic [1:0] OP, stage;
    logic       valid, new_result;

    int n_tests = 0;
    int n_fail  = 0;

    calc_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .btn_next(btn_next), .btn_clear(btn_clear),
        .A(A), .B(B), .OP(OP), .stage(stage),
        .valid(valid), .new_result(new_result)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full press + release with enough settle time for the next press.
    task automatic press_next(input logic [3:0] val);
        sw = val;
        btn_next = 1'b1;
        tick(LAT + 2);
        btn_next = 1'b0;
        tick(LAT + 4);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick(LAT + 2);
        btn_clear = 1'b0;
        tick(LAT + 4);
    endtask

    task automatic pulse_next(input int hi, input int lo);
        btn_next = 1'b1;
        tick(hi);
        btn_next = 1'b0;
        tick(lo);
    endtask

    initial begin
        rst_n = 1'b0;
        sw = 4'h0;
        btn_next = 1'b0;
        btn_clear = 1'b0;
        tick(2);
        chk("rst_A", 8'(A), 8'h0);
        chk("rst_B", 8'(B), 8'h0);
        chk("rst_OP", 8'(OP), 8'h0);
        chk("rst_stage", 8'(stage), 8'h0);
        chk("rst_valid", 8'(valid), 8'h0);
        chk("rst_new", 8'(new_result), 8'h0);
        rst_n = 1'b1;
        tick(3);

        // A capture with exact latency: unchanged through edge k+LAT, changed at k+LAT+1
        sw = 4'h3;
        btn_next = 1'b1;
        tick(LAT + 1);
        chk("a_pre_stage", 8'(stage), 8'h0);
        chk("a_pre_A", 8'(A), 8'h0);
        tick(1);
        chk("a_stage", 8'(stage), 8'h1);
        chk("a_val", 8'(A), 8'h3);
        btn_next = 1'b0;
        tick(LAT + 4);

        press_next(4'h2);
        chk("op_stage", 8'(stage), 8'h2);
        chk("op_val", 8'(OP), 8'h2);
        chk("op_valid", 8'(valid), 8'h0);

        // B capture: new_result strobe must last exactly one cycle
        sw = 4'h9;
        btn_next = 1'b1;
        tick(LAT + 2);
        chk("b_stage", 8'(stage), 8'h3);
        chk("b_val", 8'(B), 8'h9);
        chk("b_valid", 8'(valid), 8'h1);
        chk("b_new", 8'(new_result), 8'h1);
        tick(1);
        chk("b_new_off", 8'(new_result), 8'h0);
        chk("b_stage_hold", 8'(stage), 8'h3);
        btn_next = 1'b0;
        tick(LAT + 4);

        // Switch wiggle without a press is ignored
        sw = 4'hF;
        tick(5);
        chk("sw_ign_A", 8'(A), 8'h3);
        chk("sw_ign_B", 8'(B), 8'h9);

        press_next(4'hF);
        chk("done_stage", 8'(stage), 8'h0);
        chk("done_valid", 8'(valid), 8'h0);
        chk("done_A", 8'(A), 8'h3);
        chk("done_OP", 8'(OP), 8'h2);
        chk("done_B", 8'(B), 8'h9);

        press_next(4'h7);
        chk("a2_val", 8'(A), 8'h7);
        chk("a2_stage", 8'(stage), 8'h1);

        // Simultaneous clear and next in S_OP
        sw = 4'h1;
        btn_next = 1'b1;
        btn_clear = 1'b1;
        tick(LAT + 2);
        btn_next = 1'b0;
        btn_clear = 1'b0;
        tick(LAT + 4);
        chk("clr_stage", 8'(stage), 8'h0);
        chk("clr_A", 8'(A), 8'h0);
        chk("clr_OP", 8'(OP), 8'h0);
        chk("clr_B", 8'(B), 8'h0);

        // Long hold yields a single advance
        sw = 4'hA;
        btn_next = 1'b1;
        tick(100);
        btn_next = 1'b0;
        tick(LAT + 4);
        chk("hold_stage", 8'(stage), 8'h1);
        chk("hold_A", 8'(A), 8'hA);

`ifdef CALC_ENTRY_DEBOUNCE_EN
        sw = 4'h3;
        pulse_next(3, 3);
        pulse_next(1, 2);
        pulse_next(2, 1);
        pulse_next(3, 4);
        tick(10);
        chk("glitch_stage", 8'(stage), 8'h1);
        chk("glitch_OP", 8'(OP), 8'h0);
        pulse_next(2, 1);
        pulse_next(6, LAT + 6);
        chk("bounce_stage", 8'(stage), 8'h2);
        chk("bounce_OP", 8'(OP), 8'h3);
`endif

        // Reach S_B with A=5, then reset asynchronously mid-cycle
        press_clear();
        chk("clr2_stage", 8'(stage), 8'h0);
        press_next(4'h5);
        press_next(4'h1);
        chk("pre_rst_stage", 8'(stage), 8'h2);
        chk("pre_rst_A", 8'(A), 8'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_A", 8'(A), 8'h0);
        chk("arst_OP", 8'(OP), 8'h0);
        chk("arst_stage", 8'(stage), 8'h0);
        chk("arst_valid", 8'(valid), 8'h0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("idle_stage", 8'(stage), 8'h0);
        chk("idle_A", 8'(A), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
